// File: rtl/alsu_result_collector.sv
// Result FIFO for the ALSU with error tagging, running accumulator,
// error counter and sticky overflow flag.
module alsu_result_collector #(
   parameter int    DEPTH   = 4,
   parameter string SAT_SUM = "ON"
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alsu_vld,
   input  logic signed [5:0]          alsu_out,
   input  logic [15:0]                alsu_leds,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic signed [5:0]          rd_data,
   output logic                       rd_err,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic signed [9:0]          acc,
   output logic [7:0]                 err_cnt,
   output logic                       overflow
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam bit SAT = (SAT_SUM == "ON");

   logic signed [5:0] mem_data [DEPTH];
   logic              mem_err  [DEPTH];
   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic              push;
   logic              pop;
   logic              err_in;
   logic signed [10:0] sum;
   logic signed [9:0]  acc_nxt;

   assign err_in   = (alsu_leds != 16'd0);
   assign rd_valid = (count != '0);
   assign full     = (count == CW'(DEPTH));
   assign pop      = rd_valid && rd_ready;
   assign push     = alsu_vld && (!full || pop);
   assign rd_data  = rd_valid ? mem_data[head] : 6'sd0;
   assign rd_err   = rd_valid ? mem_err[head] : 1'b0;

   // 11-bit sum cannot overflow for a 10-bit acc plus a 6-bit operand
   always_comb begin
      sum     = {acc[9], acc} + {{5{alsu_out[5]}}, alsu_out};
      acc_nxt = sum[9:0];
      if (SAT) begin
         if (sum > 11'sd511)
            acc_nxt = 10'sd511;
         else if (sum < -11'sd512)
            acc_nxt = -10'sd512;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[tail] <= alsu_out;
         mem_err[tail]  <= err_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         acc      <= '0;
         err_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (push && !err_in)
            acc <= acc_nxt;
         if (push && err_in && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 1'b1;
         if (alsu_vld && !push)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alsu_result_collector.sv
// Bench for alsu_result_collector: queue-based reference model driving
// a saturating and a wrapping instance in parallel.
module tb_alsu_result_collector;

   localparam int DEPTH = 4;

   typedef struct {
      bit err;
      int data;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              alsu_vld;
   logic signed [5:0] alsu_out;
   logic [15:0]       alsu_leds;
   logic              rd_ready;

   logic              rd_valid,  w_rd_valid;
   logic signed [5:0] rd_data,   w_rd_data;
   logic              rd_err,    w_rd_err;
   logic [2:0]        count,     w_count;
   logic              full,      w_full;
   logic signed [9:0] acc,       w_acc;
   logic [7:0]        err_cnt,   w_err_cnt;
   logic              overflow,  w_overflow;

   int checks = 0;
   int errors = 0;

   ent_t q[$];
   int   m_acc_s, m_acc_w, m_err, max_cnt;
   bit   m_ovf;

   alsu_result_collector #(.DEPTH(DEPTH), .SAT_SUM("ON")) dut (
      .clk(clk), .rst(rst), .alsu_vld(alsu_vld),
      .alsu_out(alsu_out), .alsu_leds(alsu_leds),
      .rd_ready(rd_ready), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_err(rd_err), .count(count),
      .full(full), .acc(acc), .err_cnt(err_cnt),
      .overflow(overflow)
   );

   alsu_result_collector #(.DEPTH(DEPTH), .SAT_SUM("OFF")) dut_w (
      .clk(clk), .rst(rst), .alsu_vld(alsu_vld),
      .alsu_out(alsu_out), .alsu_leds(alsu_leds),
      .rd_ready(rd_ready), .rd_valid(w_rd_valid),
      .rd_data(w_rd_data), .rd_err(w_rd_err), .count(w_count),
      .full(w_full), .acc(w_acc), .err_cnt(w_err_cnt),
      .overflow(w_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wrap10(input int v);
      return ((v + 512) % 1024 + 1024) % 1024 - 512;
   endfunction

   task automatic check_all(input string tag);
      int hd, he;
      hd = (q.size() > 0) ? q[0].data : 0;
      he = (q.size() > 0) ? int'(q[0].err) : 0;
      chk({tag, ".rd_valid"}, int'(rd_valid), int'(q.size() > 0));
      chk({tag, ".rd_data"},  int'(rd_data),  hd);
      chk({tag, ".rd_err"},   int'(rd_err),   he);
      chk({tag, ".count"},    int'(count),    q.size());
      chk({tag, ".full"},     int'(full),     int'(q.size() == DEPTH));
      chk({tag, ".acc"},      int'(acc),      m_acc_s);
      chk({tag, ".err_cnt"},  int'(err_cnt),  m_err);
      chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
      chk({tag, ".w_acc"},    int'(w_acc),    m_acc_w);
      chk({tag, ".w_count"},  int'(w_count),  q.size());
      chk({tag, ".w_rd_data"}, int'(w_rd_data), hd);
   endtask

   task automatic step(input bit r, input bit v, input int o,
                       input logic [15:0] l, input bit rdy,
                       input string tag);
      bit p_pop, p_push, e;
      ent_t n;
      rst       = r;
      alsu_vld  = v;
      alsu_out  = o[5:0];
      alsu_leds = l;
      rd_ready  = rdy;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_acc_s = 0;
         m_acc_w = 0;
         m_err   = 0;
         m_ovf   = 0;
      end else begin
         e      = (l != 16'd0);
         p_pop  = (q.size() > 0) && rdy;
         p_push = v && ((q.size() < DEPTH) || p_pop);
         if (p_pop)
            void'(q.pop_front());
         if (p_push) begin
            n.err  = e;
            n.data = o;
            q.push_back(n);
            if (!e) begin
               m_acc_s = m_acc_s + o;
               if (m_acc_s > 511)  m_acc_s = 511;
               if (m_acc_s < -512) m_acc_s = -512;
               m_acc_w = wrap10(m_acc_w + o);
            end else if (m_err < 255) begin
               m_err++;
            end
         end
         if (v && !p_push)
            m_ovf = 1;
      end
      if (q.size() > max_cnt)
         max_cnt = q.size();
      #1;
      check_all(tag);
   endtask

   initial begin
      int seq_ok;
      int v, o;
      logic [15:0] l;
      bit rdy, r;

      // reset state
      step(1, 0, 0, 16'd0, 0, "reset");
      chk("reset.count_zero", int'(count), 0);

      // three pushes, consumer stalled
      step(0, 1, 5,  16'd0, 0, "p5");
      step(0, 1, -3, 16'd0, 0, "pm3");
      step(0, 1, 7,  16'd0, 0, "p7");
      step(0, 0, 0,  16'hABCD, 0, "idle_stall");
      chk("seq3.count", int'(count), 3);
      chk("seq3.head", int'(rd_data), 5);
      chk("seq3.acc", int'(acc), 9);

      // fill, then overflow, then push+pop when full
      step(0, 1, 1, 16'd0, 0, "fill4");
      step(0, 1, 9, 16'd0, 0, "drop");
      chk("drop.overflow", int'(overflow), 1);
      chk("drop.acc", int'(acc), 10);
      step(0, 1, 2, 16'd0, 1, "full_pushpop");
      chk("full_pushpop.count", int'(count), 4);
      chk("full_pushpop.acc", int'(acc), 12);

      // error entry
      step(1, 0, 0, 16'd0, 0, "rst2");
      step(0, 1, -32, 16'hFFFF, 0, "err_push");
      chk("err.rd_err", int'(rd_err), 1);
      chk("err.err_cnt", int'(err_cnt), 1);
      chk("err.acc", int'(acc), 0);

      // 17 x +31 with continuous pop
      step(1, 0, 0, 16'd0, 0, "rst3");
      for (int i = 0; i < 17; i++)
         step(0, 1, 31, 16'd0, 1, "sat");
      chk("sat.acc_on", int'(acc), 511);
      chk("sat.acc_off", int'(w_acc), -497);

      // 1..10 streamed through, order across pointer wrap
      step(1, 0, 0, 16'd0, 0, "rst4");
      max_cnt = 0;
      seq_ok = 1;
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, i, 16'd0, 1, "stream");
         if (int'(rd_data) != i) seq_ok = 0;
      end
      chk("stream.order", seq_ok, 1);
      chk("stream.max_count", max_cnt, 1);

      // reset overrides push+pop with count 3
      step(0, 1, 3, 16'd0, 0, "pre_rst_a");
      step(0, 1, 4, 16'd0, 0, "pre_rst_b");
      step(0, 0, 0, 16'd0, 0, "pre_rst_c");
      chk("pre_rst.count", int'(count), 3);
      step(1, 1, 6, 16'd0, 1, "rst_override");
      chk("rst_override.count", int'(count), 0);
      chk("rst_override.acc", int'(acc), 0);
      step(0, 1, -7, 16'd0, 0, "first_after_rst");
      chk("first_after_rst.head", int'(rd_data), -7);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 79) == 0);
         v   = ($urandom_range(0, 3) != 0);
         o   = int'($urandom_range(0, 63)) - 32;
         l   = ($urandom_range(0, 3) == 0) ? 16'($urandom) | 16'h1 : 16'd0;
         rdy = ($urandom_range(0, 2) == 0);
         step(r, v[0], o, l, rdy, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/alsu_result_collector.md
ALSU_RESULT_COLLECTOR -- requirements
Module: alsu_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, number of result-FIFO entries (power of two, 2..16).
REQ-002 Parameter SAT_SUM, default "ON", "ON" = saturating accumulator, any other value = wrapping accumulator.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alsu_vld  input  1  ALSU result on alsu_out/alsu_leds is meaningful this cycle.
REQ-006 alsu_out  input  6  signed ALSU result.
REQ-007 alsu_leds  input  16  ALSU LED vector, nonzero = invalid-operation indication.
REQ-008 rd_ready  input  1  consumer accepts head entry this cycle.
REQ-009 rd_valid  output  1  FIFO non-empty, head entry presented.
REQ-010 rd_data  output  6  signed head-entry result.
REQ-011 rd_err  output  1  head entry was captured with nonzero alsu_leds.
REQ-012 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 full  output  1  count == DEPTH.
REQ-014 acc  output  10  signed running sum of accepted non-error results.
REQ-015 err_cnt  output  8  number of accepted error entries.
REQ-016 overflow  output  1  sticky, a valid result was dropped.

Function
REQ-017 Push = alsu_vld && (!full || pop); pop = rd_valid && rd_ready.
REQ-018 Pushed entry SHALL be {err = (alsu_leds != 0), data = alsu_out}, written at tail on the push edge.
REQ-019 FIFO SHALL be first-word-fall-through: entry pushed at edge N drives rd_valid/rd_data/rd_err from edge N onward when FIFO was empty (1-cycle latency).
REQ-020 Pop SHALL advance head on the pop edge; rd_data/rd_err SHALL remain stable while rd_valid && !rd_ready.
REQ-021 Simultaneous push and pop when full SHALL both occur; count unchanged.
REQ-022 Simultaneous push and pop when empty: pop ignored (rd_valid=0), push occurs, count becomes 1.
REQ-023 Head/tail pointers SHALL wrap modulo DEPTH without loss.
REQ-024 alsu_vld while full and no pop SHALL drop the result, set overflow, leave FIFO, acc, err_cnt unchanged.
REQ-025 On push with err=0, acc SHALL add sign-extended alsu_out (10-bit).
REQ-026 With SAT_SUM="ON", acc SHALL clamp to +511 / -512; otherwise wrap two's-complement modulo 1024.
REQ-027 On push with err=1, acc SHALL be unchanged and err_cnt SHALL increment, saturating at 255.
REQ-028 alsu_vld=0 SHALL leave acc, err_cnt, overflow unchanged regardless of alsu_out/alsu_leds.
REQ-029 overflow SHALL clear only on rst.

Reset
REQ-030 rst=1 at a rising edge SHALL set count=0, rd_valid=0, full=0, acc=0, err_cnt=0, overflow=0, pointers=0; rd_data=0, rd_err=0.
REQ-031 rst SHALL override simultaneous push/pop; entries in flight are discarded.
REQ-032 First push SHALL be accepted on the edge after rst deasserts.

Verification
REQ-033 Reset, then push 5, -3, 7 (leds=0), rd_ready=0 -> count=3, rd_data=5 stable, acc=9, err_cnt=0.
REQ-034 Fill DEPTH=4 entries, then alsu_vld with rd_ready=0 -> full=1, overflow=1, count=4, acc unchanged; same with rd_ready=1 -> push and pop both occur, count=4, overflow unchanged.
REQ-035 Push alsu_out=-32 with alsu_leds=16'hFFFF -> rd_err=1 at head, err_cnt=1, acc unchanged.
REQ-036 SAT_SUM="ON", 17 pushes of +31 with continuous pop -> acc=511 after the 17th; SAT_SUM="OFF" -> acc=527-1024=-497.
REQ-037 Push/pop 10 entries 1..10 with rd_ready=1 continuously -> rd_data sequence 1..10 in order across pointer wrap, count never exceeds 1.
REQ-038 rst asserted with count=3 and simultaneous push/pop -> next cycle count=0, rd_valid=0, acc=0, overflow=0.
